// File: rtl/addr_reg_sequencer_pkg.sv
// Shared types, bit positions and strobe helpers for the address-register micro-sequencer.
package addr_seq_pkg;

   localparam int unsigned LD_W  = 6;
   localparam int unsigned SEL_W = 4;

   // ld = {inc,pc,j2,j1,m2,m1}
   localparam int unsigned LD_M1  = 0;
   localparam int unsigned LD_M2  = 1;
   localparam int unsigned LD_J1  = 2;
   localparam int unsigned LD_J2  = 3;
   localparam int unsigned LD_PC  = 4;
   localparam int unsigned LD_INC = 5;

   // sel = {j,m,inc,pc}
   localparam int unsigned SEL_PC  = 0;
   localparam int unsigned SEL_INC = 1;
   localparam int unsigned SEL_M   = 2;
   localparam int unsigned SEL_J   = 3;

   typedef enum logic [1:0] {
      LD_M_IMM = 2'b00,
      LD_J_IMM = 2'b01,
      GOTO     = 2'b10,
      JMP_M    = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE, ADDR, WAIT, LOAD, INC, XFER, DONE, ERR
   } state_t;

   typedef struct packed {
      logic             mem_rd;
      logic [LD_W-1:0]  ld;
      logic [SEL_W-1:0] sel;
      logic             busy;
      logic             done;
   } ctrl_t;

   function automatic logic [LD_W-1:0] ld_bit(input int unsigned idx);
      return LD_W'(1) << idx;
   endfunction

   function automatic logic [SEL_W-1:0] sel_bit(input int unsigned idx);
      return SEL_W'(1) << idx;
   endfunction

   // Byte 0 lands in the low half of M or J, byte 1 in the high half.
   function automatic logic [LD_W-1:0] load_target(input op_t op, input logic byte_idx);
      if (op == LD_M_IMM) return byte_idx ? ld_bit(LD_M2) : ld_bit(LD_M1);
      return byte_idx ? ld_bit(LD_J2) : ld_bit(LD_J1);
   endfunction

endpackage

// File: rtl/addr_reg_sequencer_if.sv
// Decoder/memory-facing handshake and register-unit strobe bundle of the sequencer.
interface addr_reg_sequencer_if;
   import addr_seq_pkg::*;

   logic             start;
   logic [1:0]       op;
   logic             mem_ack;
   logic             mem_rd;
   logic [LD_W-1:0]  ld;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             done;
   logic             err;

   modport master (output start, op, mem_ack,
                   input  mem_rd, ld, sel, busy, done, err);

   modport slave  (input  start, op, mem_ack,
                   output mem_rd, ld, sel, busy, done, err);
endinterface

// File: rtl/addr_reg_sequencer_timeout.sv
// Memory-ack wait counter: cleared per byte fetch, counts WAIT cycles, flags the last allowed one.
module seq_timeout_counter #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tc_c
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)       cnt_d = '0;
      else if (enable) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   // Count holds WAIT cycles already spent, so this is the final cycle an ack may arrive.
   assign tc_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/addr_reg_sequencer.sv
// Micro-sequencer issuing PC/INC/M/J load and bus-select strobes for immediate loads and jumps.
module addr_reg_sequencer
   import addr_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   addr_reg_sequencer_if.slave  bus
);

   state_t state_q, state_d;
   op_t    op_q,    op_d;
   logic   byte_q,  byte_d;
   ctrl_t  ctrl_q,  ctrl_d;
   logic   err_q,   err_d;
   logic   tc_c;
   logic   accept_c;

   assign accept_c = (state_q == IDLE) && bus.start;

   seq_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_d == ADDR),
      .enable  (state_q == WAIT),
      .tc_c    (tc_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= LD_M_IMM;
         byte_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         byte_q  <= byte_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      byte_d  = byte_q;
      case (state_q)
         IDLE: if (bus.start) begin
            op_d    = op_t'(bus.op);
            byte_d  = 1'b0;
            state_d = (op_t'(bus.op) == JMP_M) ? XFER : ADDR;
         end
         ADDR: state_d = WAIT;
         WAIT: begin
            if (bus.mem_ack) state_d = LOAD;
            else if (tc_c)   state_d = ERR;
         end
         LOAD: state_d = INC;
         INC: begin
            if (!byte_q) begin
               byte_d  = 1'b1;
               state_d = ADDR;
            end else begin
               state_d = (op_q == GOTO) ? XFER : DONE;
            end
         end
         XFER:    state_d = DONE;
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so the registered outputs line up with the state.
   always_comb begin
      ctrl_d      = '0;
      ctrl_d.busy = (state_d != IDLE);
      err_d       = err_q;
      if (accept_c)             err_d = 1'b0;
      else if (state_d == ERR)  err_d = 1'b1;
      case (state_d)
         ADDR: begin
            ctrl_d.sel    = sel_bit(SEL_PC);
            ctrl_d.ld     = ld_bit(LD_INC);
            ctrl_d.mem_rd = 1'b1;
         end
         WAIT: begin
            ctrl_d.sel    = sel_bit(SEL_PC);
            ctrl_d.mem_rd = 1'b1;
         end
         LOAD: begin
            ctrl_d.sel    = sel_bit(SEL_PC);
            ctrl_d.ld     = load_target(op_d, byte_d);
            ctrl_d.mem_rd = 1'b1;
         end
         INC: begin
            ctrl_d.sel = sel_bit(SEL_INC);
            ctrl_d.ld  = ld_bit(LD_PC);
         end
         XFER: begin
            ctrl_d.sel = (op_d == GOTO) ? sel_bit(SEL_J) : sel_bit(SEL_M);
            ctrl_d.ld  = ld_bit(LD_PC);
         end
         DONE:    ctrl_d.done = 1'b1;
         ERR:     ctrl_d.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= '0;
         err_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         err_q  <= err_d;
      end
   end

   assign bus.mem_rd = ctrl_q.mem_rd;
   assign bus.ld     = ctrl_q.ld;
   assign bus.sel    = ctrl_q.sel;
   assign bus.busy   = ctrl_q.busy;
   assign bus.done   = ctrl_q.done;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_addr_reg_sequencer.sv
// Randomised bench for addr_reg_sequencer against a per-cycle trace model built from op and ack delays.
module tb_addr_reg_sequencer;

   localparam int unsigned TO = 4;

   // ld = {inc,pc,j2,j1,m2,m1}, sel = {j,m,inc,pc}
   localparam logic [5:0] B_M1 = 6'b000001, B_M2 = 6'b000010, B_J1 = 6'b000100;
   localparam logic [5:0] B_J2 = 6'b001000, B_PC = 6'b010000, B_INC = 6'b100000;
   localparam logic [3:0] S_PC = 4'b0001, S_INC = 4'b0010, S_M = 4'b0100, S_J = 4'b1000;

   typedef struct packed {
      logic       mem_rd;
      logic [5:0] ld;
      logic [3:0] sel;
      logic       done;
      logic       err;
      logic       wt;
      logic       ack;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   addr_reg_sequencer_if seq_if ();

   addr_reg_sequencer #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (seq_if)
   );

   ent_t exp_q[$];
   logic exp_err;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic ent_t mk(input logic rd, input logic [5:0] ld, input logic [3:0] sel,
                               input logic dn, input logic er, input logic wt, input logic ack);
      ent_t e;
      e.mem_rd = rd; e.ld = ld; e.sel = sel; e.done = dn; e.err = er; e.wt = wt; e.ack = ack;
      return e;
   endfunction

   // Expected cycle-by-cycle trace from cycle 1 after the start edge; d = WAIT cycle carrying the ack
   // (out of 1..TO means no ack before timeout).
   task automatic build(input logic [1:0] op, input int d0, input int d1, output logic timed_out);
      int         d, n_wait;
      logic [5:0] tgt;
      exp_q.delete();
      timed_out = 1'b0;
      if (op == 2'b11) begin
         exp_q.push_back(mk(1'b0, B_PC, S_M, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (!timed_out) begin
               d      = (b == 0) ? d0 : d1;
               tgt    = (op == 2'b00) ? ((b == 0) ? B_M1 : B_M2) : ((b == 0) ? B_J1 : B_J2);
               n_wait = (d >= 1 && d <= int'(TO)) ? d : int'(TO);
               exp_q.push_back(mk(1'b1, B_INC, S_PC, 1'b0, 1'b0, 1'b0, 1'b0));
               for (int k = 1; k <= n_wait; k++)
                  exp_q.push_back(mk(1'b1, 6'b0, S_PC, 1'b0, 1'b0, 1'b1, k == d));
               if (d < 1 || d > int'(TO)) begin
                  timed_out = 1'b1;
                  exp_q.push_back(mk(1'b0, 6'b0, 4'b0, 1'b1, 1'b1, 1'b0, 1'b0));
               end else begin
                  exp_q.push_back(mk(1'b1, tgt, S_PC, 1'b0, 1'b0, 1'b0, 1'b0));
                  exp_q.push_back(mk(1'b0, B_PC, S_INC, 1'b0, 1'b0, 1'b0, 1'b0));
               end
            end
         end
         if (!timed_out && op == 2'b10)
            exp_q.push_back(mk(1'b0, B_PC, S_J, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      if (!timed_out)
         exp_q.push_back(mk(1'b0, 6'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},   32'(seq_if.busy),   32'(0));
      check({tag, "_done"},   32'(seq_if.done),   32'(0));
      check({tag, "_ld"},     32'(seq_if.ld),     32'(0));
      check({tag, "_sel"},    32'(seq_if.sel),    32'(0));
      check({tag, "_mem_rd"}, 32'(seq_if.mem_rd), 32'(0));
      check({tag, "_err"},    32'(seq_if.err),    32'(exp_err));
   endtask

   // One transaction launched from IDLE; abort_at >= 0 pulses reset_n during that trace cycle.
   task automatic run_txn(input logic [1:0] op, input int d0, input int d1, input bit noise,
                          input int abort_at, output int done_cyc, output int n_done);
      logic to;
      ent_t e;
      bit   aborted = 1'b0;
      build(op, d0, d1, to);
      @(negedge clk);
      check_idle("idle");
      seq_if.start   = 1'b1;
      seq_if.op      = op;
      seq_if.mem_ack = noise ? 1'($urandom) : 1'b0;
      done_cyc = 0;
      n_done   = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (!aborted) begin
            @(negedge clk);
            e = exp_q[i];
            check("mem_rd", 32'(seq_if.mem_rd), 32'(e.mem_rd));
            check("ld",     32'(seq_if.ld),     32'(e.ld));
            check("sel",    32'(seq_if.sel),    32'(e.sel));
            check("busy",   32'(seq_if.busy),   32'(1));
            check("done",   32'(seq_if.done),   32'(e.done));
            check("err",    32'(seq_if.err),    32'(e.err));
            check("sel_onehot0", 32'($countones(seq_if.sel) <= 1), 32'(1));
            check("ld_onehot0",  32'($countones(seq_if.ld) <= 1),  32'(1));
            if (seq_if.done) begin
               n_done++;
               if (done_cyc == 0) done_cyc = i + 1;
            end
            seq_if.start   = noise ? 1'($urandom) : 1'b0;
            seq_if.op      = noise ? 2'($urandom) : op;
            seq_if.mem_ack = e.wt ? e.ack : (noise ? 1'($urandom) : 1'b0);
            if (i == abort_at) begin
               #2 reset_n = 1'b0;
               #1;
               exp_err = 1'b0;
               check_idle("rst_async");
               seq_if.start   = 1'b0;
               seq_if.mem_ack = 1'b0;
               @(negedge clk);
               reset_n = 1'b1;
               check_idle("rst_hold");
               aborted = 1'b1;
            end
         end
      end
      seq_if.start = 1'b0;
      if (!aborted) exp_err = to;
   endtask

   int dc, nd;

   initial begin
      seq_if.start   = 1'b0;
      seq_if.op      = 2'b00;
      seq_if.mem_ack = 1'b0;
      exp_err        = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      reset_n = 1'b1;

      run_txn(2'b00, 1, 1, 1'b0, -1, dc, nd);
      check("ldm_done_cycle", 32'(dc), 32'(9));
      run_txn(2'b10, 3, 3, 1'b0, -1, dc, nd);
      check("goto_done_cycle", 32'(dc), 32'(14));
      run_txn(2'b11, 1, 1, 1'b0, -1, dc, nd);
      check("jmpm_done_cycle", 32'(dc), 32'(2));
      run_txn(2'b01, 0, 0, 1'b0, -1, dc, nd);
      check("timeout_done_cycle", 32'(dc), 32'(6));
      run_txn(2'b11, 1, 1, 1'b0, -1, dc, nd);
      check("err_clear_done_cycle", 32'(dc), 32'(2));
      run_txn(2'b00, 1, 1, 1'b1, -1, dc, nd);
      check("noise_done_cycle", 32'(dc), 32'(9));
      check("noise_done_count", 32'(nd), 32'(1));
      run_txn(2'b00, 1, 9, 1'b0, 5, dc, nd);

      for (int t = 0; t < 40; t++) begin
         run_txn(2'($urandom_range(0, 3)), int'($urandom_range(1, TO + 1)),
                 int'($urandom_range(1, TO + 1)), 1'b1, -1, dc, nd);
         check("rand_done_count", 32'(nd), 32'(1));
      end

      @(negedge clk);
      check_idle("final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
